// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : graphics_pkg
//  Description : Screen geometry, fragment record and writer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package graphics_pkg;

    localparam int unsigned SCREEN_W  = 320;
    localparam int unsigned SCREEN_H  = 240;
    localparam int unsigned FB_DEPTH  = 76800;
    localparam int unsigned ADDR_W    = 17;
    localparam logic [7:0]  DEPTH_FAR = 8'hFF;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [7:0]  z;
        logic [11:0] rgb;
    } fragment_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // y*320 + x built from shifts: 320 = 256 + 64
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [8:0] x, input logic [7:0] y);
        return {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
    endfunction

    function automatic logic in_screen(input logic [8:0] x, input logic [7:0] y);
        return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
    endfunction

endpackage
`default_nettype wire

// File: rtl/depth_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : depth_buffer_ram
//  Description : Simple dual-port depth store, one write port, one read port,
//                two-cycle registered read; a same-edge read returns old data.
//  Revision    : 1.0  initial release
// ============================================================================
module depth_buffer_ram #(
    parameter int unsigned DEPTH  = 76800,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rd_q1;
    logic [DATA_W-1:0] r_rd_q2;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rd_q1 <= r_mem[i_raddr];
        r_rd_q2 <= r_rd_q1;
    end

    assign o_rdata = r_rd_q2;

endmodule
`default_nettype wire

// File: rtl/fragment_depth_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fragment_depth_writer
//  Description : Three-stage fragment pipeline with depth test and full-screen
//                clear. Define DEPTH_TEST_EN to build the depth RAM, compare and
//                forwarding; without it every on-screen fragment is written.
//  Revision    : 1.0  initial release
// ============================================================================
module fragment_depth_writer
    import graphics_pkg::*;
#(
    parameter logic [11:0] CLEAR_RGB = 12'h000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [8:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [7:0]  z_in,
    input  logic [11:0] rgb_in,
    input  logic        clear_in,
    output logic        fb_we_out,
    output logic [16:0] fb_addr_out,
    output logic [11:0] fb_data_out,
    output logic        busy_out,
    output logic [15:0] drop_count_out
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_next;
    logic              w_clear_wr;

    fragment_t         w_frag;
    logic              w_accept;
    logic              w_s3_write;

    logic              r_s1_vld, r_s2_vld, r_s3_vld;
    logic [ADDR_W-1:0] r_s1_addr, r_s2_addr, r_s3_addr;
    logic [7:0]        r_s1_z, r_s2_z, r_s3_z;
    logic [11:0]       r_s1_rgb, r_s2_rgb, r_s3_rgb;

    logic              r_fb_we;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [11:0]       r_fb_data;
    logic [15:0]       r_drop_cnt;

    assign w_frag   = {x_in, y_in, z_in, rgb_in};
    assign w_accept = valid_in && (r_state == ST_IDLE) && in_screen(w_frag.x, w_frag.y);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // S3 retires on the edge that leaves DRAIN, so only S1/S2 hold it back
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_clear_wr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_in) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_s1_vld && !r_s2_vld) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                w_clear_wr = 1'b1;
                if (r_clr_cnt == c_LAST_ADDR) begin
                    w_state_next   = ST_IDLE;
                    w_clr_cnt_next = '0;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next   = ST_CLEAR;
                w_clr_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            r_s2_vld <= r_s1_vld;
            r_s3_vld <= r_s2_vld;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_s1_addr <= pixel_addr(w_frag.x, w_frag.y);
            r_s1_z    <= w_frag.z;
            r_s1_rgb  <= w_frag.rgb;
        end
        r_s2_addr <= r_s1_addr;
        r_s2_z    <= r_s1_z;
        r_s2_rgb  <= r_s1_rgb;
        r_s3_addr <= r_s2_addr;
        r_s3_z    <= r_s2_z;
        r_s3_rgb  <= r_s2_rgb;
    end

`ifdef DEPTH_TEST_EN
    logic [7:0]        r_wr_z;
    logic [7:0]        w_rd_z;
    logic [7:0]        w_eff_z;
    logic              r_h1_we, r_h2_we;
    logic [ADDR_W-1:0] r_h1_addr, r_h2_addr;
    logic [7:0]        r_h1_z, r_h2_z;

    depth_buffer_ram #(
        .DEPTH  (FB_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_depth_ram (
        .clk     (clk_in),
        .i_we    (r_fb_we),
        .i_waddr (r_fb_addr),
        .i_wdata (r_wr_z),
        .i_raddr (r_s1_addr),
        .o_rdata (w_rd_z)
    );

    // Three writes can land after the S1 read samples; newest match wins
    always_comb begin
        w_eff_z = w_rd_z;
        if (r_h2_we && (r_h2_addr == r_s3_addr)) w_eff_z = r_h2_z;
        if (r_h1_we && (r_h1_addr == r_s3_addr)) w_eff_z = r_h1_z;
        if (r_fb_we && (r_fb_addr == r_s3_addr)) w_eff_z = r_wr_z;
    end

    assign w_s3_write = r_s3_vld && (r_s3_z < w_eff_z);

    always_ff @(posedge clk_in) begin
        if (w_clear_wr) begin
            r_wr_z <= DEPTH_FAR;
        end else if (w_s3_write) begin
            r_wr_z <= r_s3_z;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_h1_we <= 1'b0;
            r_h2_we <= 1'b0;
        end else begin
            r_h1_we <= r_fb_we;
            r_h2_we <= r_h1_we;
        end
        r_h1_addr <= r_fb_addr;
        r_h1_z    <= r_wr_z;
        r_h2_addr <= r_h1_addr;
        r_h2_z    <= r_h1_z;
    end
`else
    logic w_unused_z;

    assign w_unused_z = ^r_s3_z;
    assign w_s3_write = r_s3_vld;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else if (w_clear_wr) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= r_clr_cnt;
            r_fb_data <= CLEAR_RGB;
        end else begin
            r_fb_we <= w_s3_write;
            if (w_s3_write) begin
                r_fb_addr <= r_s3_addr;
                r_fb_data <= r_s3_rgb;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_drop_cnt <= '0;
        end else if (valid_in && (r_state != ST_IDLE) && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign fb_we_out      = r_fb_we;
    assign fb_addr_out    = r_fb_addr;
    assign fb_data_out    = r_fb_data;
    assign busy_out       = (r_state != ST_IDLE);
    assign drop_count_out = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fragment_depth_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fragment_depth_writer
//  Description : Scoreboard bench: a pixel-level model predicts every frame
//                buffer write; a negedge monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fragment_depth_writer;
    import graphics_pkg::*;

    localparam logic [11:0] c_CLEAR = 12'h000;
`ifdef DEPTH_TEST_EN
    localparam bit c_DEPTH_ON = 1'b1;
`else
    localparam bit c_DEPTH_ON = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic [8:0]  x_in;
    logic [7:0]  y_in;
    logic [7:0]  z_in;
    logic [11:0] rgb_in;
    logic        clear_in;
    logic        fb_we_out;
    logic [16:0] fb_addr_out;
    logic [11:0] fb_data_out;
    logic        busy_out;
    logic [15:0] drop_count_out;

    fragment_depth_writer #(.CLEAR_RGB(c_CLEAR)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .x_in           (x_in),
        .y_in           (y_in),
        .z_in           (z_in),
        .rgb_in         (rgb_in),
        .clear_in       (clear_in),
        .fb_we_out      (fb_we_out),
        .fb_addr_out    (fb_addr_out),
        .fb_data_out    (fb_data_out),
        .busy_out       (busy_out),
        .drop_count_out (drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    // cyc < 0 means the write may appear at any cycle, only its order matters
    typedef struct {
        int cyc;
        int addr;
        int data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_we     = 0;
    int         model_drops = 0;
    bit         model_busy  = 1'b1;
    logic [7:0] model_z [0:FB_DEPTH-1];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (fb_we_out === 1'b1) begin
            n_we++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fb_write_unexpected: got addr=%0d data=%h at cyc=%0d, required no write",
                         fb_addr_out, fb_data_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (fb_addr_out !== 17'(mon_e.addr) || fb_data_out !== 12'(mon_e.data) ||
                    (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
                    n_fail++;
                    $display("FAIL fb_write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             fb_addr_out, fb_data_out, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc >= 0 && exp_q[0].cyc <= cyc) begin
            n_checks++;
            n_fail++;
            mon_e = exp_q.pop_front();
            $display("FAIL fb_write_missing: got no write at cyc=%0d, required addr=%0d data=%h",
                     cyc, mon_e.addr, mon_e.data);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic push_clear();
        for (int i = 0; i < int'(FB_DEPTH); i++) begin
            exp_q.push_back('{cyc: -1, addr: i, data: int'(c_CLEAR)});
            model_z[i] = DEPTH_FAR;
        end
    endtask

    // Called #1 after a rising edge; the inputs are sampled on the next edge
    task automatic drive(input bit v, input int x, input int y, input int z, input int rgb, input bit clr);
        int k;
        int a;
        k = cyc + 1;
        valid_in = v;
        x_in     = x[8:0];
        y_in     = y[7:0];
        z_in     = z[7:0];
        rgb_in   = rgb[11:0];
        clear_in = clr;
        if (v) begin
            if (model_busy) begin
                model_drops++;
            end else if (x < int'(SCREEN_W) && y < int'(SCREEN_H)) begin
                a = y * int'(SCREEN_W) + x;
                if (!c_DEPTH_ON || z[7:0] < model_z[a]) begin
                    model_z[a] = z[7:0];
                    exp_q.push_back('{cyc: k + 3, addr: a, data: rgb});
                end
            end
        end
        if (clr && !model_busy) begin
            model_busy = 1'b1;
            push_clear();
        end
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        clear_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wait_not_busy(input string name);
        int t;
        t = 0;
        @(negedge clk_in);
        while (busy_out !== 1'b0 && t < 80000) begin
            @(negedge clk_in);
            t++;
        end
        check(name, 32'(t < 80000), 32'd1);
        @(posedge clk_in);
        #1;
        model_busy = 1'b0;
    endtask

    initial begin
        int base;
        int x, y, r;
        rst_in = 1'b1; valid_in = 1'b0; clear_in = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; rgb_in = '0;

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_fb_we", 32'(fb_we_out), 32'd0);
        check("rst_fb_addr", 32'(fb_addr_out), 32'd0);
        check("rst_fb_data", 32'(fb_data_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd1);
        check("rst_drop", 32'(drop_count_out), 32'd0);
        @(posedge clk_in);
        #1;

        push_clear();
        rst_in = 1'b0;
        idle(100);
        @(negedge clk_in);
        check("busy_during_clear", 32'(busy_out), 32'd1);
        @(posedge clk_in);
        #1;
        wait_not_busy("init_clear_timeout");
        check("init_clear_write_count", 32'(n_we), 32'(FB_DEPTH));
        check("init_clear_queue_empty", 32'(exp_q.size()), 32'd0);

        drive(1, 10, 2, 50, 12'hF00, 0);
        idle(2);
        drive(1, 10, 2, 60, 12'h0F0, 0);
        idle(5);
        drive(1, 20, 3, 60, 12'h111, 0);
        drive(1, 20, 3, 50, 12'h222, 0);
        idle(4);
        drive(1, 21, 3, 50, 12'h333, 0);
        drive(1, 21, 3, 60, 12'h444, 0);
        idle(4);
        drive(1, 22, 3, 50, 12'h555, 0);
        drive(1, 22, 3, 50, 12'h666, 0);
        idle(4);
        drive(1, 320, 5, 10, 12'h777, 0);
        drive(1, 319, 239, 10, 12'h888, 0);
        idle(5);
        check("offscreen_no_drop", 32'(drop_count_out), 32'(model_drops));

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                x = 100 + $urandom_range(0, 3);
                y = 50 + $urandom_range(0, 1);
            end else begin
                x = $urandom_range(0, 335);
                y = $urandom_range(0, 245);
            end
            drive($urandom_range(0, 9) < 8, x, y, $urandom_range(0, 255), $urandom_range(0, 4095), 0);
        end
        idle(6);
        check("random_queue_empty", 32'(exp_q.size()), 32'd0);
        check("random_no_drop", 32'(drop_count_out), 32'(model_drops));

        drive(1, 30, 4, 20, 12'hABC, 1);
        @(negedge clk_in);
        check("busy_after_clear", 32'(busy_out), 32'd1);
        @(posedge clk_in);
        #1;
        drive(1, 31, 4, 10, 12'h123, 0);
        drive(1, 400, 4, 10, 12'h124, 0);
        drive(1, 32, 4, 10, 12'h125, 1);
        drive(1, 33, 4, 10, 12'h126, 0);
        drive(1, 34, 4, 10, 12'h127, 0);
        idle(30);
        check("drop_count_clear", 32'(drop_count_out), 32'(model_drops));
        check("drop_count_five", 32'(model_drops), 32'd5);

        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        exp_q.delete();
        model_drops = 0;
        @(negedge clk_in);
        check("midrst_fb_we", 32'(fb_we_out), 32'd0);
        check("midrst_busy", 32'(busy_out), 32'd1);
        check("midrst_drop", 32'(drop_count_out), 32'(model_drops));
        @(posedge clk_in);
        #1;
        push_clear();
        base = n_we;
        rst_in = 1'b0;
        idle(20);
        check("restart_clear_active", 32'((n_we - base) >= 15), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
